// File: rtl/axil_s_regfile.sv
// axil_s_regfile: AXI4-Lite slave register file with independent write/read FSMs
// and optional response wait states; out-of-range accesses answer SLVERR.
module axil_s_regfile #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int WR_WAIT    = 0,
    parameter int RD_WAIT    = 0
) (
    input  logic                    axi_aclk,
    input  logic                    axi_areset,
    input  logic                    cc_aa_enable,
    input  logic                    axi_awvalid,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                    axi_awready,
    input  logic                    axi_wvalid,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wready,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    output logic [1:0]              axi_bresp,
    input  logic                    axi_arvalid,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic                    axi_arready,
    output logic                    axi_rvalid,
    input  logic                    axi_rready,
    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic [1:0]              axi_rresp
);
    localparam int STRB = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(STRB);
    localparam int IW   = ADDR_WIDTH - OFF;
    localparam int MW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2;
    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic [1:0]            w_state_q, w_state_d, r_state_q, r_state_d;
    logic [2:0]            w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
    logic [IW-1:0]         w_idx_q, w_idx_d, r_idx_q, r_idx_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB-1:0]       w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic                  w_go, r_go, commit, sample, c_ok, s_ok;
    logic [IW-1:0]         c_idx, s_idx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB-1:0]       c_strb;
    logic                  unused_addr;

    assign unused_addr = ^{axi_awaddr[OFF-1:0], axi_araddr[OFF-1:0]};
    assign axi_awready = w_state_q == W_IDLE && axi_awvalid && axi_wvalid && cc_aa_enable;
    assign axi_wready  = axi_awready;
    assign axi_arready = r_state_q == R_IDLE && axi_arvalid && cc_aa_enable;
    assign axi_bvalid  = w_state_q == W_RESP;
    assign axi_rvalid  = r_state_q == R_DATA;
    assign axi_bresp   = bresp_q;
    assign axi_rresp   = rresp_q;
    assign axi_rdata   = rdata_q;

    // With no wait states the commit uses the handshake inputs directly.
    always_comb begin
        w_go      = w_state_q == W_WAIT && w_cnt_q == 3'(WR_WAIT - 1);
        commit    = (axi_awready && WR_WAIT == 0) || w_go;
        c_idx     = w_go ? w_idx_q : axi_awaddr[ADDR_WIDTH-1:OFF];
        c_data    = w_go ? w_data_q : axi_wdata;
        c_strb    = w_go ? w_strb_q : axi_wstrb;
        c_ok      = 32'(c_idx) < 32'(DEPTH);
        w_idx_d   = axi_awready ? axi_awaddr[ADDR_WIDTH-1:OFF] : w_idx_q;
        w_data_d  = axi_awready ? axi_wdata : w_data_q;
        w_strb_d  = axi_awready ? axi_wstrb : w_strb_q;
        w_cnt_d   = axi_awready ? 3'd0 : w_cnt_q + 3'd1;
        w_state_d = axi_awready ? (WR_WAIT == 0 ? W_RESP : W_WAIT)
                  : w_go ? W_RESP
                  : (w_state_q == W_RESP && axi_bready) ? W_IDLE : w_state_q;
        bresp_d   = commit ? (c_ok ? OKAY : SLVERR) : bresp_q;
    end

    always_comb begin
        mem_d = mem_q;
        for (int b = 0; b < STRB; b++)
            if (commit && c_ok && c_strb[b])
                mem_d[c_idx[MW-1:0]][8*b +: 8] = c_data[8*b +: 8];
    end

    // Sampling from mem_d makes a same-edge read see the committing write.
    always_comb begin
        r_go      = r_state_q == R_WAIT && r_cnt_q == 3'(RD_WAIT - 1);
        sample    = (axi_arready && RD_WAIT == 0) || r_go;
        s_idx     = r_go ? r_idx_q : axi_araddr[ADDR_WIDTH-1:OFF];
        s_ok      = 32'(s_idx) < 32'(DEPTH);
        r_idx_d   = axi_arready ? axi_araddr[ADDR_WIDTH-1:OFF] : r_idx_q;
        r_cnt_d   = axi_arready ? 3'd0 : r_cnt_q + 3'd1;
        r_state_d = axi_arready ? (RD_WAIT == 0 ? R_DATA : R_WAIT)
                  : r_go ? R_DATA
                  : (r_state_q == R_DATA && axi_rready) ? R_IDLE : r_state_q;
        rdata_d   = sample ? (s_ok ? mem_d[s_idx[MW-1:0]] : '0) : rdata_q;
        rresp_d   = sample ? (s_ok ? OKAY : SLVERR) : rresp_q;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            w_cnt_q   <= '0;
            r_cnt_q   <= '0;
            w_idx_q   <= '0;
            r_idx_q   <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= OKAY;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            mem_q     <= '{default: '0};
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            w_cnt_q   <= w_cnt_d;
            r_cnt_q   <= r_cnt_d;
            w_idx_q   <= w_idx_d;
            r_idx_q   <= r_idx_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
        end
    end
endmodule

// File: tb/tb_axil_s_regfile.sv
// tb_axil_s_regfile: directed checks of axil_s_regfile; instance 0 has no wait
// states, instance 1 has WR_WAIT=3 and RD_WAIT=2.
module tb_axil_s_regfile;
    logic        clk = 0;
    logic        rst [2];
    logic        en [2], awv [2], wv [2], bready [2], arv [2], rready [2];
    logic [14:0] awaddr [2], araddr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [31:0] rdata [2];
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axil_s_regfile #(.WR_WAIT(g * 3), .RD_WAIT(g * 2)) dut (
            .axi_aclk(clk), .axi_areset(rst[g]), .cc_aa_enable(en[g]),
            .axi_awvalid(awv[g]), .axi_awaddr(awaddr[g]), .axi_awready(awready[g]),
            .axi_wvalid(wv[g]), .axi_wdata(wdata[g]), .axi_wstrb(wstrb[g]), .axi_wready(wready[g]),
            .axi_bvalid(bvalid[g]), .axi_bready(bready[g]), .axi_bresp(bresp[g]),
            .axi_arvalid(arv[g]), .axi_araddr(araddr[g]), .axi_arready(arready[g]),
            .axi_rvalid(rvalid[g]), .axi_rready(rready[g]), .axi_rdata(rdata[g]), .axi_rresp(rresp[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int d, input logic [14:0] a, input logic [31:0] dt,
                            input logic [3:0] s, output logic [1:0] resp, output int lat);
        int n = 0;
        @(negedge clk);
        awaddr[d] = a; wdata[d] = dt; wstrb[d] = s; awv[d] = 1; wv[d] = 1; bready[d] = 1;
        while (!awready[d] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        awv[d] = 0; wv[d] = 0; lat = 1;
        while (!bvalid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        resp = bresp[d];
        @(posedge clk); #1;
        bready[d] = 0;
    endtask

    task automatic do_read(input int d, input logic [14:0] a, output logic [31:0] dt,
                           output logic [1:0] resp, output int lat);
        int n = 0;
        @(negedge clk);
        araddr[d] = a; arv[d] = 1; rready[d] = 1;
        while (!arready[d] && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        arv[d] = 0; lat = 1;
        while (!rvalid[d] && lat < 50) begin @(posedge clk); #1; lat++; end
        dt = rdata[d]; resp = rresp[d];
        @(posedge clk); #1;
        rready[d] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] dt;
        logic [1:0]  resp;
        int          lat;
        logic        seen;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1; en[i] = 1; awv[i] = 0; wv[i] = 0; bready[i] = 0; arv[i] = 0; rready[i] = 0;
            awaddr[i] = '0; araddr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst[0] = 0; rst[1] = 0;
        check("rst_bvalid", bvalid[0], 0);
        check("rst_rvalid", rvalid[0], 0);
        check("rst_rdata", rdata[0], 0);
        check("rst_resp", {bresp[0], rresp[0]}, 0);
        check("rst_ready", {awready[0], arready[0]}, 0);

        do_read(0, 15'h0004, dt, resp, lat);
        check("rd4_data", dt, 0);
        check("rd4_resp", resp, 2'b00);
        check("rd4_lat", lat, 1);

        do_write(0, 15'h0008, 32'hFFFFFFFF, 4'hF, resp, lat);
        check("wr8_full_resp", resp, 2'b00);
        check("wr8_lat", lat, 1);
        do_write(0, 15'h0008, 32'hA5A5A5A5, 4'b0011, resp, lat);
        check("wr8_strb_resp", resp, 2'b00);
        do_read(0, 15'h0008, dt, resp, lat);
        check("rd8_strb_data", dt, 32'hFFFFA5A5);
        do_read(0, 15'h000A, dt, resp, lat);
        check("rd_unaligned_data", dt, 32'hFFFFA5A5);

        @(negedge clk);
        awaddr[0] = 15'h0010; wdata[0] = 32'h12345678; wstrb[0] = 4'hF; awv[0] = 1; bready[0] = 1;
        repeat (3) begin
            @(negedge clk);
            check("aw_only_ready", {awready[0], wready[0]}, 2'b00);
        end
        wv[0] = 1; #1;
        check("aw_w_ready", {awready[0], wready[0]}, 2'b11);
        @(posedge clk); #1;
        check("joint_single_hs", {awready[0], bvalid[0]}, 2'b01);
        awv[0] = 0; wv[0] = 0;
        @(posedge clk); #1;
        bready[0] = 0;
        check("joint_bvalid_drop", bvalid[0], 0);
        do_read(0, 15'h0010, dt, resp, lat);
        check("rd10_data", dt, 32'h12345678);

        do_write(0, 15'h0100, 32'hDEADBEEF, 4'hF, resp, lat);
        check("wr_oor_resp", resp, 2'b10);
        do_read(0, 15'h0000, dt, resp, lat);
        check("oor_alias_data", dt, 0);
        do_read(0, 15'h0100, dt, resp, lat);
        check("rd_oor_data", dt, 0);
        check("rd_oor_resp", resp, 2'b10);
        do_write(0, 15'h00FC, 32'h0F1E2D3C, 4'hF, resp, lat);
        check("wr_last_resp", resp, 2'b00);
        do_read(0, 15'h00FC, dt, resp, lat);
        check("rd_last_data", dt, 32'h0F1E2D3C);
        check("rd_last_resp", resp, 2'b00);

        @(negedge clk);
        awaddr[0] = 15'h0020; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF; awv[0] = 1; wv[0] = 1;
        araddr[0] = 15'h0020; arv[0] = 1; bready[0] = 1; rready[0] = 1;
        @(posedge clk); #1;
        awv[0] = 0; wv[0] = 0; arv[0] = 0;
        check("wf_valids", {bvalid[0], rvalid[0]}, 2'b11);
        check("wf_rdata", rdata[0], 32'hCAFEF00D);
        @(posedge clk); #1;
        bready[0] = 0; rready[0] = 0;

        do_write(1, 15'h0000, 32'h01020304, 4'hF, resp, lat);
        check("w3_lat", lat, 4);
        check("w3_resp", resp, 2'b00);
        @(negedge clk);
        awaddr[1] = 15'h0004; wdata[1] = 32'h11223344; wstrb[1] = 4'hF; awv[1] = 1; wv[1] = 1; bready[1] = 0;
        @(posedge clk); #1;
        awv[1] = 0; wv[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("w3_bvalid_rise", bvalid[1], 1);
        repeat (5) begin
            @(posedge clk); #1;
            check("w3_bvalid_held", bvalid[1], 1);
        end
        bready[1] = 1;
        @(posedge clk); #1;
        bready[1] = 0;
        check("w3_bvalid_drop", bvalid[1], 0);
        do_read(1, 15'h0004, dt, resp, lat);
        check("r2_data", dt, 32'h11223344);
        check("r2_lat", lat, 3);

        @(negedge clk);
        awaddr[1] = 15'h0008; wdata[1] = 32'h00000055; wstrb[1] = 4'hF; awv[1] = 1; wv[1] = 1; bready[1] = 1;
        #1;
        check("rst_aw_accept", awready[1], 1);
        @(posedge clk); #1;
        awv[1] = 0; wv[1] = 0;
        check("rst_in_wait", bvalid[1], 0);
        @(negedge clk); rst[1] = 1;
        @(negedge clk); rst[1] = 0;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; seen |= bvalid[1]; end
        check("rst_no_bvalid", seen, 0);
        bready[1] = 0;
        do_read(1, 15'h0008, dt, resp, lat);
        check("rst_no_commit", dt, 0);
        do_read(1, 15'h0000, dt, resp, lat);
        check("rst_mem_zero", dt, 0);

        @(negedge clk);
        en[0] = 0; awaddr[0] = 15'h0030; wdata[0] = 32'h0BADCAFE; wstrb[0] = 4'hF;
        araddr[0] = 15'h0008; awv[0] = 1; wv[0] = 1; arv[0] = 1;
        repeat (10) begin
            @(negedge clk);
            check("en_low_ready", {awready[0], wready[0], arready[0]}, 3'b000);
        end
        en[0] = 1; #1;
        check("en_high_ready", {awready[0], wready[0], arready[0]}, 3'b111);
        @(posedge clk); #1;
        awv[0] = 0; wv[0] = 0; arv[0] = 0; bready[0] = 1; rready[0] = 1;
        check("en_valids", {bvalid[0], rvalid[0]}, 2'b11);
        check("en_rdata", rdata[0], 32'hFFFFA5A5);
        @(posedge clk); #1;
        bready[0] = 0; rready[0] = 0;
        do_read(0, 15'h0030, dt, resp, lat);
        check("en_wr_data", dt, 32'h0BADCAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axil_s_regfile.md
AXIL_S_REGFILE -- requirements
Module: axil_s_regfile

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 15, byte-address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, legal 32 or 64, data width.
REQ-003 SHALL provide parameter DEPTH, default 64, word count of the register file.
REQ-004 SHALL provide parameter WR_WAIT, default 0, range 0-7, cycles between write acceptance and bvalid beyond the minimum.
REQ-005 SHALL provide parameter RD_WAIT, default 0, range 0-7, cycles between read acceptance and rvalid beyond the minimum.
REQ-006 SHALL have one clock and a synchronous, active-high reset: axi_aclk input 1, rising-edge clock; axi_areset input 1, synchronous active-high reset.
REQ-007 SHALL have cc_aa_enable input 1, gates acceptance of new transactions.
REQ-008 SHALL have the write-address channel: axi_awvalid in 1; axi_awaddr in ADDR_WIDTH; axi_awready out 1.
REQ-009 SHALL have the write-data channel: axi_wvalid in 1; axi_wdata in DATA_WIDTH; axi_wstrb in DATA_WIDTH/8; axi_wready out 1.
REQ-010 SHALL have the write-response channel: axi_bvalid out 1; axi_bready in 1; axi_bresp out 2.
REQ-011 SHALL have the read channels: axi_arvalid in 1; axi_araddr in ADDR_WIDTH; axi_arready out 1; axi_rvalid out 1; axi_rready in 1; axi_rdata out DATA_WIDTH; axi_rresp out 2.

Function
REQ-012 SHALL compute word index = addr >> log2(DATA_WIDTH/8); unaligned low bits ignored; index >= DEPTH is out of range.
REQ-013 SHALL implement the write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE; W_WAIT is skipped when WR_WAIT=0.
REQ-014 SHALL drive axi_awready and axi_wready combinationally, both equal to (W_IDLE & awvalid & wvalid & cc_aa_enable); AW or W alone is never accepted.
REQ-015 SHALL capture address, data and strobe at acceptance, count WR_WAIT cycles in W_WAIT, then commit on the edge entering W_RESP.
REQ-016 SHALL commit only strobed bytes; an out-of-range write commits nothing.
REQ-017 SHALL hold axi_bvalid high in W_RESP until axi_bready; bresp = 2'b00 (OKAY) in range, 2'b10 (SLVERR) out of range.
REQ-018 SHALL implement the read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE, with axi_arready = R_IDLE & arvalid & cc_aa_enable, combinational.
REQ-019 SHALL register rdata on the edge entering R_DATA and hold rdata/rresp stable while rvalid=1 and rready=0.
REQ-020 SHALL return rdata = 0 and rresp = SLVERR for an out-of-range read, and OKAY otherwise.
REQ-021 SHALL give a minimum latency of 1 cycle from acceptance edge to bvalid/rvalid, plus WR_WAIT/RD_WAIT.
REQ-022 SHALL run the write and read FSMs independently; when a commit and a read sample fall on the same edge at the same index, the read returns the new data (write-first).
REQ-023 SHALL let cc_aa_enable low block only new acceptances; in-flight transactions complete normally.

Reset
REQ-024 SHALL, on axi_areset=1 at an edge, force both FSMs to IDLE, zero all DEPTH words, and drive bvalid, rvalid, bresp, rresp and rdata to 0.
REQ-025 SHALL discard any in-flight write on reset mid-transaction, with no commit and no bvalid after reset releases.

Verification
REQ-026 SHALL cover: after reset, read 0x0004 -> rdata=0, rresp=00 one cycle after the arready handshake.
REQ-027 SHALL cover: write 0x0008 data 0xA5A5A5A5, wstrb 4'b0011, over prior 0xFFFFFFFF -> bresp=00; read back 0xFFFFA5A5.
REQ-028 SHALL cover: AW valid three cycles before W -> awready stays 0 until wvalid; a single joint handshake follows.
REQ-029 SHALL cover: write 0x0100 with DEPTH=64 -> bresp=10 and memory unchanged; read 0x0100 -> rdata=0, rresp=10.
REQ-030 SHALL cover: with WR_WAIT=3, bvalid rises 4 cycles after acceptance; bready held low for 5 cycles -> bvalid held; axi_areset pulsed during W_WAIT -> no commit and no bvalid.
REQ-031 SHALL cover: with cc_aa_enable=0, awvalid, wvalid and arvalid held -> no ready for 10 cycles; enable raised -> accepted the same cycle.
